// File: rtl/br_resolve_unit_pkg.sv
// Shared RV32I type definitions: branch compare encodings and BHT counter states.
package rv32i_types;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_SLT  = 3'b010,
        BR_SLTU = 3'b011,
        BR_BLT  = 3'b100,
        BR_BGE  = 3'b101,
        BR_BLTU = 3'b110,
        BR_BGEU = 3'b111
    } branch_funct3_t;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_state_t;

    localparam bht_state_t BHT_RESET_STATE = WNT;

    // Two-bit saturating step: taken moves toward ST, not-taken toward SNT.
    function automatic logic [1:0] bht_next(input logic [1:0] cur, input logic taken);
        if (taken) begin
            return (cur == 2'b11) ? cur : cur + 2'd1;
        end
        return (cur == 2'b00) ? cur : cur - 2'd1;
    endfunction

endpackage

// File: rtl/br_resolve_unit_wide_cmp.sv
// Combinational RV32I branch / set-less-than comparator over full-width operands.
module wide_cmp
    import rv32i_types::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       cmpop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             br_en
);

    logic eq;
    logic lt;
    logic ltu;

    assign eq  = (a == b);
    assign lt  = ($signed(a) < $signed(b));
    assign ltu = (a < b);

    always_comb begin
        br_en = 1'b0;
        case (branch_funct3_t'(cmpop))
            BR_BEQ:  br_en = eq;
            BR_BNE:  br_en = !eq;
            BR_SLT:  br_en = lt;
            BR_BLT:  br_en = lt;
            BR_BGE:  br_en = !lt;
            BR_SLTU: br_en = ltu;
            BR_BLTU: br_en = ltu;
            BR_BGEU: br_en = !ltu;
            default: br_en = 1'b0;
        endcase
    end

endmodule

// File: rtl/br_resolve_unit.sv
// Branch resolution: compare, optional output register, mispredict detection,
// bimodal BHT training and saturating branch / mispredict counters.
module br_resolve_unit
    import rv32i_types::*;
#(
    parameter int WIDTH       = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int PIPE        = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pred_pc,
    output logic             pred_taken,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_cmpop,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_pc,
    input  logic             in_is_branch,
    input  logic             in_pred_taken,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_br_en,
    output logic             out_mispredict,
    output logic [WIDTH-1:0] out_pc,
    output logic [WIDTH-1:0] br_count,
    output logic [WIDTH-1:0] mispred_count
);

    localparam int IDX_W = (BHT_ENTRIES > 1) ? $clog2(BHT_ENTRIES) : 1;

    logic             br_en;
    logic             mispredict;
    logic             accept;
    logic             train;
    logic [1:0]       bht [BHT_ENTRIES];
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             unused_pc;

    wide_cmp #(.WIDTH(WIDTH)) u_cmp (
        .cmpop (in_cmpop),
        .a     (in_a),
        .b     (in_b),
        .br_en (br_en)
    );

    assign rd_idx     = pred_pc[IDX_W+1:2];
    assign wr_idx     = in_pc[IDX_W+1:2];
    assign unused_pc  = ^pred_pc;
    assign pred_taken = bht[rd_idx][1];

    // Handshake: a request transfers on in_valid && in_ready; flush vetoes the
    // transfer without touching in_ready; a result retires on out_valid && out_ready.
    assign mispredict = in_is_branch && (br_en != in_pred_taken);
    assign accept     = in_valid && in_ready && !flush;
    assign train      = accept && in_is_branch;

    // Read port sees the pre-update value in the training cycle (no bypass).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= BHT_RESET_STATE;
            end
        end else if (train) begin
            bht[wr_idx] <= bht_next(bht[wr_idx], br_en);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            br_count      <= '0;
            mispred_count <= '0;
        end else if (train) begin
            if (!(&br_count)) begin
                br_count <= br_count + 1'b1;
            end
            if (mispredict && !(&mispred_count)) begin
                mispred_count <= mispred_count + 1'b1;
            end
        end
    end

    generate
        if (PIPE != 0) begin : g_pipe
            logic             valid_q;
            logic             br_en_q;
            logic             mispredict_q;
            logic [WIDTH-1:0] pc_q;

            assign in_ready = !valid_q || out_ready;

            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_q      <= 1'b0;
                    br_en_q      <= 1'b0;
                    mispredict_q <= 1'b0;
                    pc_q         <= '0;
                end else if (flush) begin
                    valid_q <= 1'b0;
                end else if (accept) begin
                    valid_q      <= 1'b1;
                    br_en_q      <= br_en;
                    mispredict_q <= mispredict;
                    pc_q         <= in_pc;
                end else if (out_ready) begin
                    valid_q <= 1'b0;
                end
            end

            assign out_valid      = valid_q;
            assign out_br_en      = br_en_q;
            assign out_mispredict = mispredict_q;
            assign out_pc         = pc_q;
        end else begin : g_comb
            assign in_ready       = out_ready;
            assign out_valid      = in_valid && !flush;
            assign out_br_en      = br_en;
            assign out_mispredict = mispredict;
            assign out_pc         = in_pc;
        end
    endgenerate

endmodule

// File: tb/tb_br_resolve_unit.sv
// Directed bench for br_resolve_unit: registered (PIPE=1), pass-through (PIPE=0)
// and narrow WIDTH=8 instances share stimulus but have separate in_valid lines.
module tb_br_resolve_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  cmpop;
    logic [31:0] a, b, pc, pred_pc;
    logic        is_br, pin, flush, ordy;
    logic        v1, v0, v8;

    logic        r1_pred, r1_ir, r1_ov, r1_br, r1_mp;
    logic [31:0] r1_pc, r1_bc, r1_mc;
    logic        r0_pred, r0_ir, r0_ov, r0_br, r0_mp;
    logic [31:0] r0_pc, r0_bc, r0_mc;
    logic        r8_pred, r8_ir, r8_ov, r8_br, r8_mp;
    logic [7:0]  r8_pc, r8_bc, r8_mc;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    br_resolve_unit #(.WIDTH(32), .BHT_ENTRIES(64), .PIPE(1)) dut1 (
        .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(r1_pred),
        .in_valid(v1), .in_ready(r1_ir), .in_cmpop(cmpop), .in_a(a), .in_b(b),
        .in_pc(pc), .in_is_branch(is_br), .in_pred_taken(pin), .flush(flush),
        .out_valid(r1_ov), .out_ready(ordy), .out_br_en(r1_br), .out_mispredict(r1_mp),
        .out_pc(r1_pc), .br_count(r1_bc), .mispred_count(r1_mc)
    );

    br_resolve_unit #(.WIDTH(32), .BHT_ENTRIES(64), .PIPE(0)) dut0 (
        .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(r0_pred),
        .in_valid(v0), .in_ready(r0_ir), .in_cmpop(cmpop), .in_a(a), .in_b(b),
        .in_pc(pc), .in_is_branch(is_br), .in_pred_taken(pin), .flush(flush),
        .out_valid(r0_ov), .out_ready(ordy), .out_br_en(r0_br), .out_mispredict(r0_mp),
        .out_pc(r0_pc), .br_count(r0_bc), .mispred_count(r0_mc)
    );

    br_resolve_unit #(.WIDTH(8), .BHT_ENTRIES(64), .PIPE(1)) dut8 (
        .clk(clk), .rst(rst), .pred_pc(pred_pc[7:0]), .pred_taken(r8_pred),
        .in_valid(v8), .in_ready(r8_ir), .in_cmpop(cmpop), .in_a(a[7:0]), .in_b(b[7:0]),
        .in_pc(pc[7:0]), .in_is_branch(is_br), .in_pred_taken(pin), .flush(flush),
        .out_valid(r8_ov), .out_ready(ordy), .out_br_en(r8_br), .out_mispredict(r8_mp),
        .out_pc(r8_pc), .br_count(r8_bc), .mispred_count(r8_mc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        v1 = 1'b0; v0 = 1'b0; v8 = 1'b0;
        flush = 1'b0; ordy = 1'b1; is_br = 1'b0; pin = 1'b0;
        cmpop = 3'b000; a = '0; b = '0; pc = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        pred_pc = 32'h104;
        rst = 1'b1;
        tick();
        checks++; if (r1_ov !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", r1_ov); end
        checks++; if (r1_pc !== 32'h0) begin failures++; $display("FAIL reset_out_pc got=%h exp=0", r1_pc); end
        checks++; if (r1_br !== 1'b0 || r1_mp !== 1'b0) begin failures++; $display("FAIL reset_br_mp got=%b%b exp=00", r1_br, r1_mp); end
        checks++; if (r1_bc !== 32'h0 || r1_mc !== 32'h0) begin failures++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", r1_bc, r1_mc); end
        checks++; if (r1_pred !== 1'b0) begin failures++; $display("FAIL reset_pred got=%b exp=0", r1_pred); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_bltu_blt();
        do_reset();
        cmpop = 3'b110; a = 32'hFFFF_FFFF; b = 32'h1; pin = 1'b1; is_br = 1'b1; pc = 32'h100;
        v1 = 1'b1;
        tick();
        v1 = 1'b0;
        checks++; if (r1_ov !== 1'b1) begin failures++; $display("FAIL bltu_valid got=%b exp=1", r1_ov); end
        checks++; if (r1_br !== 1'b0) begin failures++; $display("FAIL bltu_br_en got=%b exp=0", r1_br); end
        checks++; if (r1_mp !== 1'b1) begin failures++; $display("FAIL bltu_mispredict got=%b exp=1", r1_mp); end
        checks++; if (r1_pc !== 32'h100) begin failures++; $display("FAIL bltu_pc got=%h exp=100", r1_pc); end
        checks++; if (r1_mc !== 32'd1 || r1_bc !== 32'd1) begin failures++; $display("FAIL bltu_counts got=%0d/%0d exp=1/1", r1_bc, r1_mc); end
        cmpop = 3'b100; pc = 32'h108;
        v1 = 1'b1;
        tick();
        v1 = 1'b0;
        checks++; if (r1_br !== 1'b1) begin failures++; $display("FAIL blt_br_en got=%b exp=1", r1_br); end
        checks++; if (r1_mp !== 1'b0) begin failures++; $display("FAIL blt_mispredict got=%b exp=0", r1_mp); end
        checks++; if (r1_bc !== 32'd2 || r1_mc !== 32'd1) begin failures++; $display("FAIL blt_counts got=%0d/%0d exp=2/1", r1_bc, r1_mc); end
        tick();
        checks++; if (r1_ov !== 1'b0) begin failures++; $display("FAIL drain_valid got=%b exp=0", r1_ov); end
    endtask

    task automatic test_bht_train();
        do_reset();
        pred_pc = 32'h104;
        #1;
        checks++; if (r1_pred !== 1'b0) begin failures++; $display("FAIL bht_init got=%b exp=0", r1_pred); end
        cmpop = 3'b000; a = 32'd7; b = 32'd7; is_br = 1'b1; pin = 1'b0; pc = 32'h104;
        v1 = 1'b1;
        #1;
        checks++; if (r1_pred !== 1'b0) begin failures++; $display("FAIL bht_no_bypass got=%b exp=0", r1_pred); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++; if (r1_pred !== 1'b1) begin failures++; $display("FAIL bht_taken_%0d got=%b exp=1", i, r1_pred); end
        end
        cmpop = 3'b001;
        tick();
        checks++; if (r1_pred !== 1'b1) begin failures++; $display("FAIL bht_wt got=%b exp=1", r1_pred); end
        pred_pc = 32'h204;
        #1;
        checks++; if (r1_pred !== 1'b1) begin failures++; $display("FAIL bht_alias got=%b exp=1", r1_pred); end
        tick();
        v1 = 1'b0;
        checks++; if (r1_pred !== 1'b0) begin failures++; $display("FAIL bht_wnt got=%b exp=0", r1_pred); end
        checks++; if (r1_bc !== 32'd5 || r1_mc !== 32'd3) begin failures++; $display("FAIL bht_counts got=%0d/%0d exp=5/3", r1_bc, r1_mc); end
    endtask

    task automatic test_stall();
        do_reset();
        ordy = 1'b0; pred_pc = 32'h304;
        cmpop = 3'b000; a = 32'd1; b = 32'd1; is_br = 1'b1; pin = 1'b1; pc = 32'h300;
        v1 = 1'b1;
        tick();
        checks++; if (r1_ov !== 1'b1 || r1_pc !== 32'h300) begin failures++; $display("FAIL stall_first got=%b/%h exp=1/300", r1_ov, r1_pc); end
        pin = 1'b0; pc = 32'h304;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (r1_ir !== 1'b0) begin failures++; $display("FAIL stall_ready_%0d got=%b exp=0", i, r1_ir); end
            checks++; if (r1_pc !== 32'h300 || r1_ov !== 1'b1 || r1_br !== 1'b1 || r1_mp !== 1'b0) begin
                failures++; $display("FAIL stall_hold_%0d got=%h/%b/%b/%b exp=300/1/1/0", i, r1_pc, r1_ov, r1_br, r1_mp); end
            checks++; if (r1_bc !== 32'd1 || r1_pred !== 1'b0) begin failures++; $display("FAIL stall_noupd_%0d got=%0d/%b exp=1/0", i, r1_bc, r1_pred); end
        end
        ordy = 1'b1;
        #1;
        checks++; if (r1_ir !== 1'b1) begin failures++; $display("FAIL release_ready got=%b exp=1", r1_ir); end
        tick();
        checks++; if (r1_pc !== 32'h304 || r1_bc !== 32'd2 || r1_pred !== 1'b1) begin
            failures++; $display("FAIL b2b_0 got=%h/%0d/%b exp=304/2/1", r1_pc, r1_bc, r1_pred); end
        pc = 32'h308;
        tick();
        checks++; if (r1_pc !== 32'h308 || r1_bc !== 32'd3) begin failures++; $display("FAIL b2b_1 got=%h/%0d exp=308/3", r1_pc, r1_bc); end
        pc = 32'h30c;
        tick();
        checks++; if (r1_pc !== 32'h30c || r1_bc !== 32'd4 || r1_ov !== 1'b1) begin failures++; $display("FAIL b2b_2 got=%h/%0d exp=30c/4", r1_pc, r1_bc); end
        v1 = 1'b0;
        tick();
        checks++; if (r1_ov !== 1'b0 || r1_mc !== 32'd3) begin failures++; $display("FAIL b2b_end got=%b/%0d exp=0/3", r1_ov, r1_mc); end
    endtask

    task automatic test_flush();
        do_reset();
        pred_pc = 32'h104;
        cmpop = 3'b000; a = 32'd5; b = 32'd5; is_br = 1'b1; pin = 1'b0; pc = 32'h104;
        v1 = 1'b1; flush = 1'b1;
        #1;
        checks++; if (r1_ir !== 1'b1) begin failures++; $display("FAIL flush_ready got=%b exp=1", r1_ir); end
        tick();
        flush = 1'b0; v1 = 1'b0;
        checks++; if (r1_ov !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", r1_ov); end
        checks++; if (r1_bc !== 32'd0 || r1_pred !== 1'b0) begin failures++; $display("FAIL flush_noupd got=%0d/%b exp=0/0", r1_bc, r1_pred); end
        v1 = 1'b1;
        tick();
        v1 = 1'b0; ordy = 1'b0; flush = 1'b1;
        checks++; if (r1_ov !== 1'b1) begin failures++; $display("FAIL flush_pre got=%b exp=1", r1_ov); end
        tick();
        flush = 1'b0; ordy = 1'b1;
        checks++; if (r1_ov !== 1'b0 || r1_bc !== 32'd1) begin failures++; $display("FAIL flush_inflight got=%b/%0d exp=0/1", r1_ov, r1_bc); end
    endtask

    task automatic test_non_branch();
        do_reset();
        cmpop = 3'b010; a = 32'hFFFF_FFFD; b = 32'd2; is_br = 1'b0; pin = 1'b1;
        pc = 32'h400; pred_pc = 32'h400;
        v1 = 1'b1;
        tick();
        v1 = 1'b0;
        checks++; if (r1_br !== 1'b1 || r1_mp !== 1'b0) begin failures++; $display("FAIL slt_result got=%b/%b exp=1/0", r1_br, r1_mp); end
        checks++; if (r1_bc !== 32'd0 || r1_mc !== 32'd0 || r1_pred !== 1'b0) begin
            failures++; $display("FAIL slt_noupd got=%0d/%0d/%b exp=0/0/0", r1_bc, r1_mc, r1_pred); end
    endtask

    task automatic test_saturate();
        do_reset();
        cmpop = 3'b000; a = '0; b = '0; is_br = 1'b1; pin = 1'b0; pc = '0;
        v8 = 1'b1;
        repeat (255) tick();
        checks++; if (r8_bc !== 8'd255 || r8_mc !== 8'd255) begin failures++; $display("FAIL sat_reach got=%0d/%0d exp=255/255", r8_bc, r8_mc); end
        tick();
        v8 = 1'b0;
        checks++; if (r8_bc !== 8'd255 || r8_mc !== 8'd255) begin failures++; $display("FAIL sat_hold got=%0d/%0d exp=255/255", r8_bc, r8_mc); end
    endtask

    task automatic test_reset_mid();
        idle();
        ordy = 1'b0; cmpop = 3'b000; a = 32'd9; b = 32'd9; is_br = 1'b1; pc = 32'h500;
        v1 = 1'b1;
        tick();
        v1 = 1'b0;
        pred_pc = 32'h500;
        #1;
        checks++; if (r1_ov !== 1'b1 || r1_pred !== 1'b1) begin failures++; $display("FAIL mid_pre got=%b/%b exp=1/1", r1_ov, r1_pred); end
        rst = 1'b1;
        tick();
        rst = 1'b0; ordy = 1'b1;
        checks++; if (r1_ov !== 1'b0 || r1_pc !== 32'h0) begin failures++; $display("FAIL mid_valid got=%b/%h exp=0/0", r1_ov, r1_pc); end
        checks++; if (r1_bc !== 32'd0 || r1_mc !== 32'd0) begin failures++; $display("FAIL mid_counts got=%0d/%0d exp=0/0", r1_bc, r1_mc); end
        for (int i = 0; i < 64; i++) begin
            pred_pc = i << 2;
            #1;
            checks++; if (r1_pred !== 1'b0) begin failures++; $display("FAIL mid_bht_%0d got=%b exp=0", i, r1_pred); end
        end
    endtask

    task automatic test_pipe0();
        do_reset();
        cmpop = 3'b110; a = 32'hFFFF_FFFF; b = 32'd1; pin = 1'b1; is_br = 1'b1; pc = 32'h600;
        v0 = 1'b1;
        #1;
        checks++; if (r0_ov !== 1'b1 || r0_ir !== 1'b1) begin failures++; $display("FAIL p0_valid got=%b/%b exp=1/1", r0_ov, r0_ir); end
        checks++; if (r0_br !== 1'b0 || r0_mp !== 1'b1 || r0_pc !== 32'h600) begin
            failures++; $display("FAIL p0_bltu got=%b/%b/%h exp=0/1/600", r0_br, r0_mp, r0_pc); end
        tick();
        v0 = 1'b0;
        #1;
        checks++; if (r0_bc !== 32'd1 || r0_mc !== 32'd1 || r0_ov !== 1'b0) begin
            failures++; $display("FAIL p0_counts got=%0d/%0d/%b exp=1/1/0", r0_bc, r0_mc, r0_ov); end
        cmpop = 3'b100;
        #1;
        checks++; if (r0_br !== 1'b1 || r0_mp !== 1'b0) begin failures++; $display("FAIL p0_blt got=%b/%b exp=1/0", r0_br, r0_mp); end
        v0 = 1'b1; flush = 1'b1;
        #1;
        checks++; if (r0_ov !== 1'b0 || r0_ir !== 1'b1) begin failures++; $display("FAIL p0_flush got=%b/%b exp=0/1", r0_ov, r0_ir); end
        tick();
        flush = 1'b0; ordy = 1'b0;
        #1;
        checks++; if (r0_bc !== 32'd1 || r0_ir !== 1'b0 || r0_ov !== 1'b1) begin
            failures++; $display("FAIL p0_stall got=%0d/%b/%b exp=1/0/1", r0_bc, r0_ir, r0_ov); end
        tick();
        v0 = 1'b0; ordy = 1'b1;
        checks++; if (r0_bc !== 32'd1) begin failures++; $display("FAIL p0_stall_cnt got=%0d exp=1", r0_bc); end
    endtask

    task automatic test_compare_table();
        logic [31:0] ta [3];
        logic [31:0] tb [3];
        logic [7:0]  te [3];
        ta[0] = 32'hFFFF_FFFD; tb[0] = 32'd2;          te[0] = 8'b1001_0110;
        ta[1] = 32'd5;         tb[1] = 32'd5;          te[1] = 8'b1010_0001;
        ta[2] = 32'h8000_0000; tb[2] = 32'h7FFF_FFFF;  te[2] = 8'b1001_0110;
        idle();
        for (int v = 0; v < 3; v++) begin
            for (int op = 0; op < 8; op++) begin
                a = ta[v]; b = tb[v]; cmpop = op[2:0];
                #1;
                checks++; if (r0_br !== te[v][op]) begin
                    failures++; $display("FAIL cmp_v%0d_op%0d got=%b exp=%b", v, op, r0_br, te[v][op]); end
            end
        end
    endtask

    initial begin
        idle();
        rst = 1'b1;
        pred_pc = '0;
        test_reset();
        test_bltu_blt();
        test_bht_train();
        test_stall();
        test_flush();
        test_non_branch();
        test_saturate();
        test_reset_mid();
        test_pipe0();
        test_compare_table();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
